// File: rtl/vga_pkg.sv
// Shared types and default 640x480@60 timing for the VGA raster timing generator.
package vga_pkg;

  localparam int COORD_W = 16;

  typedef enum logic [1:0] {
    ST_ACT  = 2'd0,
    ST_FP   = 2'd1,
    ST_SYNC = 2'd2,
    ST_BP   = 2'd3
  } timing_state_e;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FRONT  = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BACK   = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT  = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BACK   = 33;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping position counter plus its ACT/FP/SYNC/BP phase FSM.
// The state register is loaded from the next count, so count and state always agree.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FRONT  = DEF_H_FRONT,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BACK   = DEF_H_BACK
) (
  input  logic               i_pix_clk,
  input  logic               i_rst_n,
  input  logic               i_step,
  output logic [COORD_W-1:0] o_count,
  output timing_state_e      o_state,
  output logic               o_wrap
);

  localparam logic [COORD_W-1:0] LAST       = COORD_W'(ACTIVE + FRONT + SYNC + BACK - 1);
  localparam logic [COORD_W-1:0] FP_START   = COORD_W'(ACTIVE);
  localparam logic [COORD_W-1:0] SYNC_START = COORD_W'(ACTIVE + FRONT);
  localparam logic [COORD_W-1:0] BP_START   = COORD_W'(ACTIVE + FRONT + SYNC);

  logic [COORD_W-1:0] r_count;
  logic [COORD_W-1:0] w_next_count;
  timing_state_e      r_state;
  timing_state_e      w_next_state;
  logic               w_wrap;

  always_ff @(posedge i_pix_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= LAST;
      r_state <= ST_BP;
    end else begin
      r_count <= w_next_count;
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_wrap       = i_step && (r_count == LAST);
    w_next_count = r_count;
    if (i_step) begin
      w_next_count = w_wrap ? '0 : r_count + COORD_W'(1);
    end
    w_next_state = r_state;
    if (i_step) begin
      case (r_state)
        ST_ACT:  if (w_next_count == FP_START)   w_next_state = ST_FP;
        ST_FP:   if (w_next_count == SYNC_START) w_next_state = ST_SYNC;
        ST_SYNC: if (w_next_count == BP_START)   w_next_state = ST_BP;
        ST_BP:   if (w_wrap)                     w_next_state = ST_ACT;
        default:                                 w_next_state = ST_ACT;
      endcase
    end
  end

  always_comb begin
    o_count = r_count;
    o_state = r_state;
    o_wrap  = w_wrap;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing generator: coords over the full raster, blank flags, syncs, strobes.
// Define VGA_TIMING_PIPE_EN to delay hsync/vsync by SYNC_DELAY cycles (coords/flags unaffected).
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE   = DEF_H_ACTIVE,
  parameter int   H_FRONT    = DEF_H_FRONT,
  parameter int   H_SYNC     = DEF_H_SYNC,
  parameter int   H_BACK     = DEF_H_BACK,
  parameter int   V_ACTIVE   = DEF_V_ACTIVE,
  parameter int   V_FRONT    = DEF_V_FRONT,
  parameter int   V_SYNC     = DEF_V_SYNC,
  parameter int   V_BACK     = DEF_V_BACK,
  parameter logic SYNC_POL   = 1'b0,
  parameter int   SYNC_DELAY = 2
) (
  input  logic               i_pix_clk,
  input  logic               i_rst_n,
  output logic [COORD_W-1:0] o_horz_coord,
  output logic [COORD_W-1:0] o_vert_coord,
  output logic               o_in_active_area,
  output logic               o_horz_blank,
  output logic               o_vert_blank,
  output logic               o_hsync,
  output logic               o_vsync,
  output logic               o_line_start,
  output logic               o_frame_start
);

  if (SYNC_DELAY < 1) begin : g_bad_sync_delay
    $error("SYNC_DELAY must be at least 1");
  end

  logic [COORD_W-1:0] w_h_count;
  logic [COORD_W-1:0] w_v_count;
  timing_state_e      w_h_state;
  timing_state_e      w_v_state;
  logic               w_h_wrap;
  logic               w_v_wrap;
  logic               w_hsync;
  logic               w_vsync;
  logic               r_line_start;
  logic               r_frame_start;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FRONT  (H_FRONT),
    .SYNC   (H_SYNC),
    .BACK   (H_BACK)
  ) u_h_counter (
    .i_pix_clk (i_pix_clk),
    .i_rst_n   (i_rst_n),
    .i_step    (1'b1),
    .o_count   (w_h_count),
    .o_state   (w_h_state),
    .o_wrap    (w_h_wrap)
  );

  // Vertical axis advances once per line, on the horizontal wrap edge.
  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FRONT  (V_FRONT),
    .SYNC   (V_SYNC),
    .BACK   (V_BACK)
  ) u_v_counter (
    .i_pix_clk (i_pix_clk),
    .i_rst_n   (i_rst_n),
    .i_step    (w_h_wrap),
    .o_count   (w_v_count),
    .o_state   (w_v_state),
    .o_wrap    (w_v_wrap)
  );

  // A wrap this cycle means the count lands on 0 at the edge, so the strobes line up with coords.
  always_ff @(posedge i_pix_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_line_start  <= w_h_wrap;
      r_frame_start <= w_v_wrap;
    end
  end

  always_comb begin
    w_hsync = (w_h_state == ST_SYNC) ? SYNC_POL : ~SYNC_POL;
    w_vsync = (w_v_state == ST_SYNC) ? SYNC_POL : ~SYNC_POL;
  end

`ifdef VGA_TIMING_PIPE_EN
  logic [SYNC_DELAY-1:0] r_hsync_pipe;
  logic [SYNC_DELAY-1:0] r_vsync_pipe;

  always_ff @(posedge i_pix_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hsync_pipe <= {SYNC_DELAY{~SYNC_POL}};
      r_vsync_pipe <= {SYNC_DELAY{~SYNC_POL}};
    end else begin
      r_hsync_pipe[0] <= w_hsync;
      r_vsync_pipe[0] <= w_vsync;
      for (int i = 1; i < SYNC_DELAY; i++) begin
        r_hsync_pipe[i] <= r_hsync_pipe[i-1];
        r_vsync_pipe[i] <= r_vsync_pipe[i-1];
      end
    end
  end

  assign o_hsync = r_hsync_pipe[SYNC_DELAY-1];
  assign o_vsync = r_vsync_pipe[SYNC_DELAY-1];
`else
  assign o_hsync = w_hsync;
  assign o_vsync = w_vsync;
`endif

  assign o_horz_coord     = w_h_count;
  assign o_vert_coord     = w_v_count;
  assign o_in_active_area = (w_h_state == ST_ACT) && (w_v_state == ST_ACT);
  assign o_horz_blank     = (w_h_state != ST_ACT);
  assign o_vert_blank     = (w_v_state != ST_ACT);
  assign o_line_start     = r_line_start;
  assign o_frame_start    = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: default 640x480 instance plus a tiny active-high-sync raster, both checked every cycle
// against an arithmetic model driven only by the number of clock edges since reset release.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [15:0] h;
    logic [15:0] v;
    logic        act;
    logic        hb;
    logic        vb;
    logic        hs;
    logic        vs;
    logic        ls;
    logic        fs;
  } obs_t;

`ifdef VGA_TIMING_PIPE_EN
  localparam int SD = 2;
`else
  localparam int SD = 0;
`endif

  logic clk;
  logic rst_n;
  int   k;
  int   n_cmp;
  int   n_bad;

  logic [15:0] b_h, b_v, s_h, s_v;
  logic b_act, b_hb, b_vb, b_hs, b_vs, b_ls, b_fs;
  logic s_act, s_hb, s_vb, s_hs, s_vs, s_ls, s_fs;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  vga_timing_gen u_dut_big (
    .i_pix_clk        (clk),
    .i_rst_n          (rst_n),
    .o_horz_coord     (b_h),
    .o_vert_coord     (b_v),
    .o_in_active_area (b_act),
    .o_horz_blank     (b_hb),
    .o_vert_blank     (b_vb),
    .o_hsync          (b_hs),
    .o_vsync          (b_vs),
    .o_line_start     (b_ls),
    .o_frame_start    (b_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE (20), .H_FRONT (3), .H_SYNC (5), .H_BACK (4),
    .V_ACTIVE (10), .V_FRONT (2), .V_SYNC (2), .V_BACK (3),
    .SYNC_POL (1'b1), .SYNC_DELAY (2)
  ) u_dut_small (
    .i_pix_clk        (clk),
    .i_rst_n          (rst_n),
    .o_horz_coord     (s_h),
    .o_vert_coord     (s_v),
    .o_in_active_area (s_act),
    .o_horz_blank     (s_hb),
    .o_vert_blank     (s_vb),
    .o_hsync          (s_hs),
    .o_vsync          (s_vs),
    .o_line_start     (s_ls),
    .o_frame_start    (s_fs)
  );

  // ---------------- reference model ----------------
  // Raster position after kk edges since release; kk <= 0 is the reset position (last pixel).
  function automatic int pos_of(input int kk, input int f);
    return (kk <= 0) ? f - 1 : (kk - 1) % f;
  endfunction

  function automatic obs_t model(input int kk, input int ha, input int hf, input int hs,
                                 input int hb, input int va, input int vf, input int vs,
                                 input int vb, input logic pol);
    int   ht, vt, f, p, h, v, pd, hd, vd;
    obs_t o;
    ht   = ha + hf + hs + hb;
    vt   = va + vf + vs + vb;
    f    = ht * vt;
    p    = pos_of(kk, f);
    h    = p % ht;
    v    = p / ht;
    pd   = pos_of(kk - SD, f);
    hd   = pd % ht;
    vd   = pd / ht;
    o.h   = 16'(h);
    o.v   = 16'(v);
    o.act = (h < ha) && (v < va);
    o.hb  = (h >= ha);
    o.vb  = (v >= va);
    o.hs  = (hd >= ha + hf && hd < ha + hf + hs) ? pol : ~pol;
    o.vs  = (vd >= va + vf && vd < va + vf + vs) ? pol : ~pol;
    o.ls  = (h == 0);
    o.fs  = (h == 0) && (v == 0);
    return o;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [38:0] obs, input logic [38:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      if (n_bad <= 20)
        $display("FAIL %s edge=%0d got=%h expected=%h (h,v,act,hb,vb,hs,vs,ls,fs)",
                 tag, k, obs, exp);
    end
  endtask

  task automatic check_all();
    check("big",   {b_h, b_v, b_act, b_hb, b_vb, b_hs, b_vs, b_ls, b_fs},
          model(k, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0));
    check("small", {s_h, s_v, s_act, s_hb, s_vb, s_hs, s_vs, s_ls, s_fs},
          model(k, 20, 3, 5, 4, 10, 2, 2, 3, 1'b1));
  endtask

  // ---------------- driver tasks ----------------
  task automatic run_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      check_all();
    end
  endtask

  // Asserts reset between edges, checks the asynchronous effect, holds, then releases.
  task automatic pulse_reset(input int hold);
    @(negedge clk);
    #($urandom_range(1, 3));
    rst_n = 1'b0;
    k     = 0;
    #1;
    check_all();
    repeat (hold) begin
      @(negedge clk);
      check_all();
    end
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_cmp = 0;
    n_bad = 0;
    k     = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all();
    rst_n = 1'b1;
    run_cycles(2000);
    for (int seg = 0; seg < 14; seg++) begin
      pulse_reset($urandom_range(1, 4));
      run_cycles($urandom_range(200, 3000));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
